transmitter_control: RTL and testbench

//  Block-transmit controller; the sending-side counterpart of the receive-side write controller.
//  On Start, reads Length+1 consecutive 16-bit words from the shared word memory, starting at address 0.

---
 rtl/transmitter_control.sv | 152 +++++++++++++++
 tb/tb_transmitter_control.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/transmitter_control.sv
// transmitter_control: reads Length+1 words from memory and hands each to the serial transmitter over a 4-phase Send/Ack handshake.
// Optional CHECKSUM_EN appends an XOR checksum word, which then carries Ready instead of the last data word.
module transmitter_control #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Length,
    input  logic [DATA_W-1:0] memDataOut,
    output logic [ADDR_W-1:0] Address,
    output logic              ReadEnable,
    output logic [DATA_W-1:0] sndDataIn,
    output logic              Send,
    input  logic              Ack,
    output logic              Ready,
    output logic              Busy,
    output logic              Done
);
`ifdef CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, WAIT_ACK, WAIT_REL, CSUM, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, WAIT_ACK, WAIT_REL, DONE} state_t;
`endif
    state_t state, state_n;
    logic [ADDR_W-1:0] idx, idx_n, len, len_n, addr_n;
    logic [DATA_W-1:0] data_n;
    logic re_n, send_n, ready_n, busy_n, done_n, last;
`ifdef CHECKSUM_EN
    logic [DATA_W-1:0] csum, csum_n;
    logic csum_sent, csum_sent_n;
`endif

    assign last = idx == len;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            idx        <= '0;
            len        <= '0;
            Address    <= '0;
            ReadEnable <= 1'b0;
            sndDataIn  <= '0;
            Send       <= 1'b0;
            Ready      <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
`ifdef CHECKSUM_EN
            csum       <= '0;
            csum_sent  <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            len        <= len_n;
            Address    <= addr_n;
            ReadEnable <= re_n;
            sndDataIn  <= data_n;
            Send       <= send_n;
            Ready      <= ready_n;
            Busy       <= busy_n;
            Done       <= done_n;
`ifdef CHECKSUM_EN
            csum       <= csum_n;
            csum_sent  <= csum_sent_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        len_n   = len;
        addr_n  = Address;
        re_n    = 1'b0;
        data_n  = sndDataIn;
        send_n  = Send;
        ready_n = Ready;
        busy_n  = Busy;
        done_n  = 1'b0;
`ifdef CHECKSUM_EN
        csum_n      = csum;
        csum_sent_n = csum_sent;
`endif
        case (state)
            IDLE: if (Start && !Ack) begin
                len_n   = Length;
                idx_n   = '0;
                busy_n  = 1'b1;
                state_n = FETCH;
`ifdef CHECKSUM_EN
                csum_n      = '0;
                csum_sent_n = 1'b0;
`endif
            end
            FETCH: begin
                addr_n  = idx;
                re_n    = 1'b1;
                state_n = LOAD;
            end
            LOAD: begin
                data_n  = memDataOut;
                send_n  = 1'b1;
                state_n = WAIT_ACK;
`ifdef CHECKSUM_EN
                ready_n = 1'b0;
                csum_n  = csum ^ memDataOut;
`else
                ready_n = last;
`endif
            end
            WAIT_ACK: if (Ack) begin
                send_n  = 1'b0;
                ready_n = 1'b0;
                state_n = WAIT_REL;
            end
            WAIT_REL: if (!Ack) begin
`ifdef CHECKSUM_EN
                // the checksum handshake reuses WAIT_ACK/WAIT_REL; csum_sent tells them apart
                if (csum_sent) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else if (last) begin
                    state_n = CSUM;
                end else begin
                    idx_n   = idx + 1'b1;
                    state_n = FETCH;
                end
`else
                state_n = last ? DONE : FETCH;
                idx_n   = last ? idx : idx + 1'b1;
                done_n  = last;
`endif
            end
`ifdef CHECKSUM_EN
            CSUM: begin
                data_n      = csum;
                send_n      = 1'b1;
                ready_n     = 1'b1;
                csum_sent_n = 1'b1;
                state_n     = WAIT_ACK;
            end
`endif
            DONE: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_transmitter_control.sv
// tb_transmitter_control: table-driven block transfers against a combinational word memory, plus reset and ignored-Start sequences.
module tb_transmitter_control;
`ifdef CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    logic clk = 1'b0, Reset = 1'b0, Start = 1'b0, Ack = 1'b0;
    logic [3:0] Length = '0;
    logic [15:0] memDataOut;
    logic [3:0] Address;
    logic ReadEnable, Send, Ready, Busy, Done;
    logic [15:0] sndDataIn;
    logic [15:0] mem [16];
    logic [3:0] addr_q[$];
    int checks = 0, errors = 0, done_cnt = 0;

    typedef struct {
        int len;
        int pat;
        int dly;
        int hold;
        bit busy_start;
        int hs;
        logic [15:0] last;
    } vec_t;
    vec_t vt [5];

    transmitter_control dut (
        .clk(clk), .Reset(Reset), .Start(Start), .Length(Length), .memDataOut(memDataOut),
        .Address(Address), .ReadEnable(ReadEnable), .sndDataIn(sndDataIn), .Send(Send),
        .Ack(Ack), .Ready(Ready), .Busy(Busy), .Done(Done)
    );

    always #5 clk = ~clk;
    assign memDataOut = mem[Address];

    always @(posedge clk) begin
        if (ReadEnable) addr_q.push_back(Address);
        if (Done) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill(input int pat);
        for (int i = 0; i < 16; i++)
            mem[i] = pat == 0 ? 16'(16'h1111 * (i + 1)) : pat == 1 ? (i == 0 ? 16'hBEEF : 16'h0000) : 16'(i);
    endtask

    task automatic run_block(input vec_t v);
        int a0, d0;
        logic [15:0] held;
        fill(v.pat);
        a0 = addr_q.size();
        d0 = done_cnt;
        @(negedge clk);
        Length = 4'(v.len);
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        check("busy_rise", Busy, 1);
        check("send_early", Send, 0);
        @(negedge clk);
        check("re_first", ReadEnable, 1);
        check("addr_first", Address, 0);
        @(negedge clk);
        check("send_latency", Send, 1);
        for (int w = 0; w < v.hs; w++) begin
            for (int k = 0; k < 50 && !Send; k++) @(negedge clk);
            if (!Send) begin
                check("send_timeout", Send, 1);
                return;
            end
            check("data", sndDataIn, w <= v.len ? mem[w] : v.last);
            check("ready", Ready, w == v.hs - 1);
            if (w == v.hs - 1) check("last_word", sndDataIn, v.last);
            held = sndDataIn;
            if (v.busy_start) Start = 1'b1;
            repeat (v.dly) begin
                @(negedge clk);
                check("hold_send", Send, 1);
                check("hold_data", sndDataIn, held);
            end
            Ack = 1'b1;
            Start = 1'b0;
            @(negedge clk);
            check("send_drop", Send, 0);
            check("ready_drop", Ready, 0);
            repeat (v.hold) begin
                @(negedge clk);
                check("no_fetch", ReadEnable, 0);
            end
            Ack = 1'b0;
        end
        for (int k = 0; k < 50 && !Done; k++) @(negedge clk);
        check("done", Done, 1);
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        check("done_pulse", Done, 0);
        check("busy_fall", Busy, 0);
        check("done_cnt", done_cnt - d0, 1);
        repeat (3) @(negedge clk);
        check("idle_after", Busy, 0);
        check("reads", addr_q.size() - a0, v.len + 1);
        for (int i = 0; i <= v.len && a0 + i < addr_q.size(); i++) check("addr_seq", addr_q[a0 + i], i);
    endtask

    initial begin
        vt[0] = '{3, 0, 0, 0, 1'b0, 4 + CS, 16'h4444};
        vt[1] = '{0, 1, 0, 0, 1'b0, 1 + CS, 16'hBEEF};
        vt[2] = '{15, 2, 0, 0, 1'b0, 16 + CS, CS ? 16'h0000 : 16'h000F};
        vt[3] = '{2, 0, 20, 10, 1'b0, 3 + CS, CS ? 16'h0000 : 16'h3333};
        vt[4] = '{1, 2, 0, 0, 1'b1, 2 + CS, 16'h0001};
        fill(0);
        #12;
        check("rst_addr", Address, 0);
        check("rst_re", ReadEnable, 0);
        check("rst_data", sndDataIn, 0);
        check("rst_send", Send, 0);
        check("rst_ready", Ready, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        @(negedge clk);
        Reset = 1'b1;
        for (int t = 0; t < 5; t++) run_block(vt[t]);

        Ack = 1'b1;
        Start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("ack_start_busy", Busy, 0);
            check("ack_start_re", ReadEnable, 0);
        end
        Start = 1'b0;
        Ack = 1'b0;

        fill(0);
        @(negedge clk);
        Length = 4'd5;
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 50 && !Send; k++) @(negedge clk);
            check("rst_seq_send", Send, 1);
            if (w < 2) begin
                Ack = 1'b1;
                @(negedge clk);
                Ack = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
        #2 Reset = 1'b0;
        #1;
        check("abort_send", Send, 0);
        check("abort_busy", Busy, 0);
        check("abort_data", sndDataIn, 0);
        check("abort_addr", Address, 0);
        check("abort_ready", Ready, 0);
        @(negedge clk);
        Reset = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_idle", Busy, 0);
        run_block(vt[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
